// File: rtl/mips_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   ST_*       : arbiter FSM state codes
//   arbState_t : FSM state type built on those codes
//   GRANT_I/D  : owner tag of the access in flight
//   STARVE_W   : width of the fetch-starvation counter (covers STARVE_MAX up to 15)
package mips_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUS_I = 2'd1;
   localparam logic [1:0] ST_BUS_D = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      BUS_I = ST_BUS_I,
      BUS_D = ST_BUS_D,
      DONE  = ST_DONE
   } arbState_t;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants made while a fetch was waiting.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   dataGrant     : a data access is granted this cycle
//   fetchGrant    : a fetch access is granted this cycle (clears the count)
//   fetchPending  : IReqF, sampled with the grant
//   starve_hit    : count has reached STARVE_MAX; fetch must win the next grant
module arb_starve_ctr
   import mips_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic dataGrant,
   input  logic fetchGrant,
   input  logic fetchPending,
   output logic starve_hit
);

   localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0] starveCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starveCnt <= '0;
      end else if (fetchGrant) begin
         starveCnt <= '0;
      end else if (dataGrant && fetchPending && (starveCnt != CNT_MAX)) begin
         starveCnt <= starveCnt + 1'b1;
      end
   end

   assign starve_hit = (starveCnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between the F-stage fetch
// and the M-stage load/store. Data has priority; a starvation counter
// forces a fetch grant after STARVE_MAX data grants taken while fetch waited.
// Each access runs IDLE -> BUS_I/BUS_D -> DONE -> IDLE.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   IReqF, IAddrF                 : fetch request (held until IReadyF) and address
//   IRdataF, IReadyF, IStall      : fetched word, one-cycle completion, fetch stall
//   DReqM, DWeM, DAddrM, DWdataM  : data request (held until DReadyM), store flag, address, store data
//   DRdataM, DReadyM, DStall      : load data, one-cycle completion, data stall
//   MemReq, MemWe, MemAddr, MemWdata, MemRdata, MemAck : memory handshake
//   MemErr                        : sticky ack-timeout flag (MEM_TIMEOUT_EN builds only)
// Build option: define MEM_TIMEOUT_EN to add the TIMEOUT-cycle ack watchdog
// and the MemErr port; without it a BUS state waits for MemAck indefinitely.
module mem_port_arbiter
   import mips_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          IReqF,
   input  logic [AW-1:0] IAddrF,
   output logic [DW-1:0] IRdataF,
   output logic          IReadyF,
   output logic          IStall,
   input  logic          DReqM,
   input  logic          DWeM,
   input  logic [AW-1:0] DAddrM,
   input  logic [DW-1:0] DWdataM,
   output logic [DW-1:0] DRdataM,
   output logic          DReadyM,
   output logic          DStall,
   output logic          MemReq,
   output logic          MemWe,
   output logic [AW-1:0] MemAddr,
   output logic [DW-1:0] MemWdata,
   input  logic [DW-1:0] MemRdata,
   input  logic          MemAck
`ifdef MEM_TIMEOUT_EN
   ,
   output logic          MemErr
`endif
);

   arbState_t     state, stateNext;
   logic          grantSel;
   logic          winI, winD;
   logic          starveHit;
   logic          busy, finish, wdExpire;
   logic [DW-1:0] captureData;

   assign busy = (state == BUS_I) || (state == BUS_D);

   arb_starve_ctr #(
      .STARVE_MAX(STARVE_MAX)
   ) uStarve (
      .clk         (clk),
      .rst_n       (rst_n),
      .dataGrant   (winD),
      .fetchGrant  (winI),
      .fetchPending(IReqF),
      .starve_hit  (starveHit)
   );

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   logic [7:0] wdCnt;
   logic       memErrQ;

   // An ack arriving in the last allowed cycle still wins over the timeout.
   assign wdExpire = busy && !MemAck && (wdCnt == WD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdCnt   <= '0;
         memErrQ <= 1'b0;
      end else begin
         wdCnt <= busy ? (wdCnt + 8'd1) : 8'd0;
         if (wdExpire) begin
            memErrQ <= 1'b1;
         end
      end
   end

   assign MemErr = memErrQ;
`else
   logic unusedTimeout;
   assign unusedTimeout = ^TIMEOUT;
   assign wdExpire      = 1'b0;
`endif

   assign finish      = busy && (MemAck || wdExpire);
   assign captureData = wdExpire ? '0 : MemRdata;

   // Requests are only looked at in IDLE, so the requester's update after
   // its Ready pulse (in DONE) can never cause a second grant.
   always_comb begin
      stateNext = state;
      winI      = 1'b0;
      winD      = 1'b0;
      case (state)
         IDLE: begin
            if (DReqM && !(IReqF && starveHit)) begin
               winD      = 1'b1;
               stateNext = BUS_D;
            end else if (IReqF) begin
               winI      = 1'b1;
               stateNext = BUS_I;
            end
         end
         BUS_I, BUS_D: begin
            if (finish) begin
               stateNext = DONE;
            end
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grantSel <= GRANT_I;
         MemAddr  <= '0;
         MemWe    <= 1'b0;
         MemWdata <= '0;
         IRdataF  <= '0;
         DRdataM  <= '0;
      end else begin
         if (winD) begin
            grantSel <= GRANT_D;
            MemAddr  <= DAddrM;
            MemWe    <= DWeM;
            MemWdata <= DWdataM;
         end else if (winI) begin
            grantSel <= GRANT_I;
            MemAddr  <= IAddrF;
            MemWe    <= 1'b0;
         end
         if (finish) begin
            if (grantSel == GRANT_D) begin
               DRdataM <= captureData;
            end else begin
               IRdataF <= captureData;
            end
         end
      end
   end

   // Decoded from state so an asserted reset clears them without a clock edge.
   assign MemReq  = busy;
   assign IReadyF = (state == DONE) && (grantSel == GRANT_I);
   assign DReadyM = (state == DONE) && (grantSel == GRANT_D);
   assign IStall  = IReqF && !IReadyF;
   assign DStall  = DReqM && !DReadyM;

endmodule
